wavetable_interp: RTL

WAVETABLE_INTERP -- requirements
Module: wavetable_interp

---
 rtl/wavetable_pkg.sv | 19 +
 rtl/wt_lerp.sv | 30 +++
 rtl/wavetable_interp.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wavetable_pkg.sv
// Shared defaults and FSM encoding for the wavetable interpolator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wavetable_pkg;

    localparam int WT_AW_DEFAULT = 12;
    localparam int WT_IW_DEFAULT = 20;
    localparam int WT_FW_DEFAULT = 16;
    localparam int WT_SW_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WAIT = 3'd3,
        CALC = 3'd4
    } wt_state_t;

endpackage

// File: rtl/wt_lerp.sv
// Combinational linear interpolation: y = s0 + floor((s1 - s0) * f / 2^FW).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: s0, s1 signed SW-bit endpoints; f unsigned FW-bit fraction; y signed SW-bit result.
module wt_lerp #(
    parameter int SW = 16,
    parameter int FW = 16
) (
    input  logic signed [SW-1:0] s0,
    input  logic signed [SW-1:0] s1,
    input  logic        [FW-1:0] f,
    output logic signed [SW-1:0] y
);

    logic signed [SW:0]       diff;
    logic signed [FW:0]       f_ext;
    logic signed [SW+FW+1:0]  prod;
    logic signed [SW+FW+1:0]  shifted;
    logic signed [SW+FW+1:0]  sum;

    // One extra bit on the difference so s1 - s0 cannot overflow.
    assign diff    = $signed({s1[SW-1], s1}) - $signed({s0[SW-1], s0});
    assign f_ext   = $signed({1'b0, f});
    assign prod    = diff * f_ext;
    // Arithmetic shift floors toward -inf, so the result never leaves [s0, s1].
    assign shifted = prod >>> FW;
    assign sum     = shifted + $signed({{(FW+2){s0[SW-1]}}, s0});
    assign y       = sum[SW-1:0];

endmodule

// File: rtl/wavetable_interp.sv
// Wavetable sample fetch with optional linear interpolation between adjacent entries.
// Latency: Enable at edge k -> sampleValid after edge k+4 (linear) or k+3 (nearest).
// Backpressure: none; requests arriving while busy are dropped and set sticky overrun.
// Ports: Clk/Reset (sync, active-high); Enable, wavetableAddr, interp request inputs;
//        memAddr/memRdData single-port table read (data one cycle after address);
//        sampleOut/sampleValid result; busy status; overrun sticky drop flag.
// Build option: define WAVETABLE_INTERP_LINEAR_EN for linear interpolation; otherwise
//        the table entry at wavetableAddr is returned and interp is ignored.
module wavetable_interp
    import wavetable_pkg::*;
#(
    parameter int AW = WT_AW_DEFAULT,
    parameter int IW = WT_IW_DEFAULT,
    parameter int FW = WT_FW_DEFAULT,
    parameter int SW = WT_SW_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [AW-1:0]        wavetableAddr,
    input  logic [IW-1:0]        interp,
    output logic [AW-1:0]        memAddr,
    input  logic signed [SW-1:0] memRdData,
    output logic signed [SW-1:0] sampleOut,
    output logic                 sampleValid,
    output logic                 busy,
    output logic                 overrun
);

    wt_state_t             state;
    wt_state_t             state_nxt;
    logic [AW-1:0]         a;
    logic signed [SW-1:0]  s0;
    logic signed [SW-1:0]  result;
    logic                  unused_interp;

`ifdef WAVETABLE_INTERP_LINEAR_EN
    logic [FW-1:0]         f;
    logic signed [SW-1:0]  s1;

    wt_lerp #(.SW(SW), .FW(FW)) u_lerp (
        .s0 (s0),
        .s1 (s1),
        .f  (f),
        .y  (result)
    );
`else
    assign result = s0;
`endif

    // Only the top FW fraction bits feed the datapath; the rest are intentionally dropped.
    assign unused_interp = ^interp;

    assign busy = (state != IDLE);
    // The second table entry is addressed only in RD1; AW-bit add wraps the top entry to 0.
    assign memAddr = (state == RD1) ? a + AW'(1) : a;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Enable) state_nxt = RD0;
            RD0:  state_nxt = RD1;
`ifdef WAVETABLE_INTERP_LINEAR_EN
            RD1:  state_nxt = WAIT;
            WAIT: state_nxt = CALC;
`else
            RD1:  state_nxt = CALC;
`endif
            CALC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a           <= '0;
            s0          <= '0;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            overrun     <= 1'b0;
`ifdef WAVETABLE_INTERP_LINEAR_EN
            f           <= '0;
            s1          <= '0;
`endif
        end else begin
            sampleValid <= 1'b0;
            if (state == IDLE && Enable) begin
                a <= wavetableAddr;
`ifdef WAVETABLE_INTERP_LINEAR_EN
                f <= interp[IW-1 -: FW];
`endif
            end
            // Includes the CALC->IDLE edge: the FSM is still busy when it samples Enable.
            if (state != IDLE && Enable) begin
                overrun <= 1'b1;
            end
            if (state == RD1) begin
                s0 <= memRdData;
            end
`ifdef WAVETABLE_INTERP_LINEAR_EN
            if (state == WAIT) begin
                s1 <= memRdData;
            end
`endif
            if (state == CALC) begin
                sampleOut   <= result;
                sampleValid <= 1'b1;
            end
        end
    end

endmodule
